// File: rtl/hw_itr_retpc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hw_itr_retpc_ctrl_pkg
// Description : Shared types and helpers for the hardware-interrupt return-PC
//               controller (FSM state encoding, latched redirect record).
// Revision    : 1.0 - initial release
// ============================================================================
package hw_itr_retpc_ctrl_pkg;

  // Upper bounds for the redirect record; the controller zero-extends into
  // these fields so one record type serves every NUM_WARPS/XLEN build.
  localparam int HW_ITR_ADDR_MAX_W = 64;
  localparam int HW_ITR_WID_MAX_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } hw_itr_state_t;

  typedef struct packed {
    logic [HW_ITR_WID_MAX_W-1:0]  wid;
    logic [HW_ITR_ADDR_MAX_W-1:0] addr;
  } hw_itr_redirect_t;

  // Next round-robin start position after granting idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage : hw_itr_retpc_ctrl_pkg
`default_nettype wire

// File: rtl/hw_itr_retpc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hw_itr_retpc_ctrl_if
// Description : Execute-stage / warp-scheduler interface of the return-PC
//               controller. The controller is the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hw_itr_retpc_ctrl_if #(
  parameter int NUM_WARPS = 4,
  parameter int XLEN      = 32,
  parameter int WID_W     = $clog2(NUM_WARPS)
);
  logic                 commit_ret_pc;
  logic [WID_W-1:0]     commit_wid;
  logic [XLEN-1:0]      ret_pc;
  logic                 commit_ret_pc_w0;
  logic [XLEN-1:0]      ret_pc_w0;
  logic                 all_hit;
  logic                 write_wspawn;
  logic [XLEN-1:0]      wspawn_pc4;
  logic [NUM_WARPS-1:0] ret_req;
  logic [NUM_WARPS-1:0] ret_gnt;
  logic                 overload_jal;
  logic [XLEN-1:0]      ret_handler_addr;
  logic [WID_W-1:0]     redirect_wid;
  logic                 redirect_ready;
  logic [NUM_WARPS-1:0] saved_mask;
  logic                 err_overwrite;
  logic                 err_nopc;

  modport master (
    output commit_ret_pc, commit_wid, ret_pc, commit_ret_pc_w0, ret_pc_w0,
           all_hit, write_wspawn, wspawn_pc4, ret_req, redirect_ready,
    input  ret_gnt, overload_jal, ret_handler_addr, redirect_wid,
           saved_mask, err_overwrite, err_nopc
  );

  modport slave (
    input  commit_ret_pc, commit_wid, ret_pc, commit_ret_pc_w0, ret_pc_w0,
           all_hit, write_wspawn, wspawn_pc4, ret_req, redirect_ready,
    output ret_gnt, overload_jal, ret_handler_addr, redirect_wid,
           saved_mask, err_overwrite, err_nopc
  );
endinterface : hw_itr_retpc_ctrl_if
`default_nettype wire

// File: rtl/hw_itr_retpc_ctrl_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : hw_itr_retpc_ctrl_rr_arb
// Description : Combinational round-robin picker. Returns the first active
//               request at or after ptr_i (wrapping) as one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module hw_itr_retpc_ctrl_rr_arb #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic                valid_o,
  output logic [NUM_REQS-1:0] onehot_o,
  output logic [IDX_W-1:0]    idx_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQS);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  assign valid_o  = found;
  assign onehot_o = found ? (NUM_REQS'(1) << idx_o) : '0;

endmodule : hw_itr_retpc_ctrl_rr_arb
`default_nettype wire

// File: rtl/hw_itr_retpc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hw_itr_retpc_ctrl
// Description : Owns saved SIMT-scheduler return PCs for HW-interrupt handlers,
//               arbitrates handler returns round-robin and drives the
//               overloaded-JAL redirect back to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module hw_itr_retpc_ctrl
  import hw_itr_retpc_ctrl_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int XLEN      = 32
) (
  input  logic               clk,
  input  logic               reset,
  hw_itr_retpc_ctrl_if.slave itr_if
);

  localparam int WID_W = $clog2(NUM_WARPS);

  logic [XLEN-1:0]      slot_q [NUM_WARPS];
  logic [NUM_WARPS-1:0] saved_q;
  logic [XLEN-1:0]      wspawn_pc_q;
  logic                 wspawn_vld_q;
  logic [WID_W-1:0]     rr_ptr_q;
  hw_itr_state_t        state_q;
  hw_itr_redirect_t     redir_q;
  logic [NUM_WARPS-1:0] redir_oh_q;
  logic                 redir_fresh_q;   // slot re-committed after the target was latched
  logic [NUM_WARPS-1:0] gnt_q;
  logic                 jal_q;
  logic                 err_ow_q;
  logic                 err_nopc_q;

  logic [NUM_WARPS-1:0] w_commit_set;
  logic [XLEN-1:0]      w_commit_val [NUM_WARPS];
  logic                 w_commit_hit;
  logic [NUM_WARPS-1:0] w_drain_hit;
  logic [NUM_WARPS-1:0] w_drain_clr;
  logic                 w_pick_vld;
  logic [NUM_WARPS-1:0] w_pick_oh;
  logic [WID_W-1:0]     w_pick_idx;
  logic [XLEN-1:0]      w_target;

  hw_itr_retpc_ctrl_rr_arb #(
    .NUM_REQS (NUM_WARPS),
    .IDX_W    (WID_W)
  ) u_rr_arb (
    .req_i    (itr_if.ret_req),
    .ptr_i    (rr_ptr_q),
    .valid_o  (w_pick_vld),
    .onehot_o (w_pick_oh),
    .idx_o    (w_pick_idx)
  );

  assign w_commit_hit = itr_if.commit_ret_pc & itr_if.all_hit;

  // Per-slot commit decode; the dedicated warp-0 port beats the generic one.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_commit
    if (w == 0) begin : g_w0
      assign w_commit_set[w] = itr_if.commit_ret_pc_w0 |
                               (w_commit_hit & (itr_if.commit_wid == WID_W'(w)));
      assign w_commit_val[w] = itr_if.commit_ret_pc_w0 ? itr_if.ret_pc_w0 : itr_if.ret_pc;
    end else begin : g_wn
      assign w_commit_set[w] = w_commit_hit & (itr_if.commit_wid == WID_W'(w));
      assign w_commit_val[w] = itr_if.ret_pc;
    end
  end

  // DRAIN releases the granted slot unless newer data arrived after the latch.
  assign w_drain_hit = (state_q == DRAIN) ? redir_oh_q : '0;
  assign w_drain_clr = redir_fresh_q ? '0 : w_drain_hit;

  // Redirect target: saved PC first, then the wspawn PC, else zero.
  always_comb begin
    w_target = '0;
    if (saved_q[w_pick_idx]) begin
      w_target = slot_q[w_pick_idx];
    end else if (wspawn_vld_q) begin
      w_target = wspawn_pc_q;
    end
  end

  // Return-PC slot capture, independent of the FSM; a set beats a DRAIN clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) slot_q[w] <= '0;
      saved_q  <= '0;
      err_ow_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_commit_set[w]) slot_q[w] <= w_commit_val[w];
      end
      saved_q <= (saved_q & ~w_drain_clr) | w_commit_set;
      if (|(w_commit_set & saved_q & ~w_drain_hit)) err_ow_q <= 1'b1;
    end
  end

  // Return FSM with registered redirect/grant outputs and wspawn bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      redir_q       <= '0;
      redir_oh_q    <= '0;
      redir_fresh_q <= 1'b0;
      gnt_q         <= '0;
      jal_q         <= 1'b0;
      rr_ptr_q      <= '0;
      wspawn_pc_q   <= '0;
      wspawn_vld_q  <= 1'b0;
      err_nopc_q    <= 1'b0;
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (w_pick_vld) begin
            state_q       <= REDIRECT;
            jal_q         <= 1'b1;
            redir_q.wid   <= HW_ITR_WID_MAX_W'(w_pick_idx);
            redir_q.addr  <= HW_ITR_ADDR_MAX_W'(w_target);
            redir_oh_q    <= w_pick_oh;
            redir_fresh_q <= |(w_commit_set & w_pick_oh);
            if (!saved_q[w_pick_idx]) begin
              if (wspawn_vld_q) wspawn_vld_q <= 1'b0;
              else              err_nopc_q   <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          if (|(w_commit_set & redir_oh_q)) redir_fresh_q <= 1'b1;
          if (itr_if.redirect_ready) begin
            state_q <= DRAIN;
            jal_q   <= 1'b0;
            gnt_q   <= redir_oh_q;
          end
        end
        DRAIN: begin
          state_q  <= IDLE;
          rr_ptr_q <= WID_W'(rr_next(32'(redir_q.wid), NUM_WARPS));
        end
        default: state_q <= IDLE;
      endcase
      if (itr_if.write_wspawn) begin
        wspawn_pc_q  <= itr_if.wspawn_pc4;
        wspawn_vld_q <= 1'b1;
      end
    end
  end

  // Upper bits of the shared redirect record are never populated here.
  if (XLEN < HW_ITR_ADDR_MAX_W) begin : g_addr_pad
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^redir_q.addr[HW_ITR_ADDR_MAX_W-1:XLEN];
  end
  if (WID_W < HW_ITR_WID_MAX_W) begin : g_wid_pad
    logic w_unused_wid_hi;
    assign w_unused_wid_hi = ^redir_q.wid[HW_ITR_WID_MAX_W-1:WID_W];
  end

  assign itr_if.ret_gnt          = gnt_q;
  assign itr_if.overload_jal     = jal_q;
  assign itr_if.ret_handler_addr = redir_q.addr[XLEN-1:0];
  assign itr_if.redirect_wid     = redir_q.wid[WID_W-1:0];
  assign itr_if.saved_mask       = saved_q;
  assign itr_if.err_overwrite    = err_ow_q;
  assign itr_if.err_nopc         = err_nopc_q;

endmodule : hw_itr_retpc_ctrl
`default_nettype wire

// File: tb/tb_hw_itr_retpc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hw_itr_retpc_ctrl
// Description : Directed scoreboard bench for hw_itr_retpc_ctrl (4 warps).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hw_itr_retpc_ctrl;

  localparam int NW    = 4;
  localparam int XL    = 32;
  localparam int WID_W = 2;

  typedef struct {
    int          wid;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

  exp_t exp_redir[$];
  int   exp_gnt[$];

  hw_itr_retpc_ctrl_if #(.NUM_WARPS(NW), .XLEN(XL)) bif ();

  hw_itr_retpc_ctrl #(.NUM_WARPS(NW), .XLEN(XL)) dut (
    .clk    (clk),
    .reset  (reset),
    .itr_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Monitor: redirects are checked every cycle they are shown (so the held
  // value is checked during backpressure) and retired on acceptance.
  always @(negedge clk) begin
    logic [3:0] eg;
    if (!reset) begin
      if (bif.overload_jal) begin
        total++;
        if (exp_redir.size() == 0) begin
          bad++;
          $display("FAIL redirect_unexpected: wid=%0d addr=%h", bif.redirect_wid, bif.ret_handler_addr);
        end else begin
          if (bif.redirect_wid !== WID_W'(exp_redir[0].wid) || bif.ret_handler_addr !== exp_redir[0].addr) begin
            bad++;
            $display("FAIL redirect: got wid=%0d addr=%h, want wid=%0d addr=%h",
                     bif.redirect_wid, bif.ret_handler_addr, exp_redir[0].wid, exp_redir[0].addr);
          end
          if (bif.redirect_ready) void'(exp_redir.pop_front());
        end
      end
      if (bif.ret_gnt != '0) begin
        total++;
        if (exp_gnt.size() == 0) begin
          bad++;
          $display("FAIL grant_unexpected: ret_gnt=%b", bif.ret_gnt);
        end else begin
          eg = 4'b0001 << exp_gnt.pop_front();
          if (bif.ret_gnt !== eg) begin
            bad++;
            $display("FAIL grant: got %b, want %b", bif.ret_gnt, eg);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a grant to warp w; returns the cycle stamp it was seen.
  task automatic wait_gnt(input int w, output int at);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bif.ret_gnt[w]) seen = 1'b1;
    end
    at = cyc;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL grant_wait w%0d: got no grant, want one within 50 cycles", w);
    end
  endtask

  task automatic ret_one(input int w, input logic [31:0] addr);
    int at;
    exp_redir.push_back('{w, addr});
    exp_gnt.push_back(w);
    bif.ret_req[w] = 1'b1;
    wait_gnt(w, at);
    bif.ret_req[w] = 1'b0;
    tick();
  endtask

  task automatic commit(input int w, input logic [31:0] pc, input logic hit);
    bif.commit_ret_pc = 1'b1;
    bif.commit_wid    = WID_W'(w);
    bif.ret_pc        = pc;
    bif.all_hit       = hit;
    tick();
    bif.commit_ret_pc = 1'b0;
    bif.all_hit       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int t [5];
    total = 0;
    bad   = 0;
    cyc   = 0;
    bif.commit_ret_pc    = 1'b0;
    bif.commit_wid       = '0;
    bif.ret_pc           = '0;
    bif.commit_ret_pc_w0 = 1'b0;
    bif.ret_pc_w0        = '0;
    bif.all_hit          = 1'b0;
    bif.write_wspawn     = 1'b0;
    bif.wspawn_pc4       = '0;
    bif.ret_req          = '0;
    bif.redirect_ready   = 1'b1;
    do_reset();

    // Reset state
    chk("rst_jal",   64'(bif.overload_jal), 64'd0);
    chk("rst_gnt",   64'(bif.ret_gnt), 64'd0);
    chk("rst_saved", 64'(bif.saved_mask), 64'd0);
    chk("rst_addr",  64'(bif.ret_handler_addr), 64'd0);
    chk("rst_errs",  64'({bif.err_overwrite, bif.err_nopc}), 64'd0);

    // Basic return of warp 2
    commit(2, 32'h8000_0100, 1'b1);
    chk("basic_saved", 64'(bif.saved_mask), 64'b0100);
    exp_redir.push_back('{2, 32'h8000_0100});
    exp_gnt.push_back(2);
    bif.ret_req = 4'b0100;
    tick();
    chk("basic_latency_jal", 64'(bif.overload_jal), 64'd1);
    begin
      int at;
      wait_gnt(2, at);
    end
    bif.ret_req = '0;
    tick();
    chk("basic_saved_clr", 64'(bif.saved_mask), 64'd0);
    chk("basic_errs", 64'({bif.err_overwrite, bif.err_nopc}), 64'd0);

    // all_hit gating, then wspawn fallback and its consumption
    commit(1, 32'h0000_1234, 1'b0);
    chk("gate_saved", 64'(bif.saved_mask), 64'd0);
    ret_one(1, 32'h0);
    chk("gate_err_nopc", 64'(bif.err_nopc), 64'd1);
    bif.write_wspawn = 1'b1;
    bif.wspawn_pc4   = 32'h200;
    tick();
    bif.write_wspawn = 1'b0;
    ret_one(1, 32'h200);
    ret_one(1, 32'h0);

    // Warp-0 port wins over a same-cycle generic commit to slot 0
    bif.commit_ret_pc_w0 = 1'b1;
    bif.ret_pc_w0        = 32'h222;
    commit(0, 32'h111, 1'b1);
    bif.commit_ret_pc_w0 = 1'b0;
    chk("w0_saved", 64'(bif.saved_mask), 64'b0001);
    chk("w0_no_overwrite", 64'(bif.err_overwrite), 64'd0);
    ret_one(0, 32'h222);

    // Round-robin fairness from a fresh pointer
    do_reset();
    bif.commit_ret_pc_w0 = 1'b1;
    bif.ret_pc_w0        = 32'hA000;
    commit(1, 32'hA004, 1'b1);
    bif.commit_ret_pc_w0 = 1'b0;
    commit(2, 32'hA008, 1'b1);
    commit(3, 32'hA00C, 1'b1);
    chk("rr_saved_all", 64'(bif.saved_mask), 64'b1111);
    exp_redir.push_back('{0, 32'hA000});
    exp_redir.push_back('{1, 32'hA004});
    exp_redir.push_back('{2, 32'hA008});
    exp_redir.push_back('{3, 32'hA00C});
    exp_redir.push_back('{0, 32'hB000});
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    bif.ret_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(k % 4, t[k]);
      if (k == 0) begin
        // Re-commit warp 0 in its own DRAIN cycle: the new value must survive.
        bif.commit_ret_pc_w0 = 1'b1;
        bif.ret_pc_w0        = 32'hB000;
        @(posedge clk);
        #1;
        bif.commit_ret_pc_w0 = 1'b0;
      end
    end
    bif.ret_req = '0;
    tick();
    for (int k = 1; k < 5; k++) chk($sformatf("rr_period_%0d", k), 64'(t[k] - t[k-1]), 64'd3);
    chk("rr_no_overwrite", 64'(bif.err_overwrite), 64'd0);
    chk("rr_saved_clr", 64'(bif.saved_mask), 64'd0);

    // Backpressure with a same-warp commit during the stall
    commit(2, 32'h500, 1'b1);
    exp_redir.push_back('{2, 32'h500});
    exp_gnt.push_back(2);
    bif.redirect_ready = 1'b0;
    bif.ret_req[2]     = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) commit(2, 32'h999, 1'b1);
      else        tick();
    end
    chk("bp_addr_held", 64'(bif.ret_handler_addr), 64'h500);
    chk("bp_jal_held", 64'(bif.overload_jal), 64'd1);
    bif.redirect_ready = 1'b1;
    begin
      int at;
      wait_gnt(2, at);
    end
    bif.ret_req[2] = 1'b0;
    tick();
    chk("bp_saved_kept", 64'(bif.saved_mask), 64'b0100);
    ret_one(2, 32'h999);

    // Reset while a redirect is pending
    commit(3, 32'h777, 1'b1);
    exp_redir.push_back('{3, 32'h777});
    bif.redirect_ready = 1'b0;
    bif.ret_req[3]     = 1'b1;
    tick();
    chk("rstmid_jal_before", 64'(bif.overload_jal), 64'd1);
    reset          = 1'b1;
    bif.ret_req[3] = 1'b0;
    tick();
    reset = 1'b0;
    exp_redir.delete();
    exp_gnt.delete();
    chk("rstmid_jal", 64'(bif.overload_jal), 64'd0);
    chk("rstmid_saved", 64'(bif.saved_mask), 64'd0);
    chk("rstmid_errs", 64'({bif.err_overwrite, bif.err_nopc}), 64'd0);
    bif.redirect_ready = 1'b1;
    ret_one(3, 32'h0);
    chk("rstmid_err_nopc", 64'(bif.err_nopc), 64'd1);

    tick();
    chk("sb_redir_empty", 64'(exp_redir.size()), 64'd0);
    chk("sb_gnt_empty", 64'(exp_gnt.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hw_itr_retpc_ctrl
`default_nettype wire
